// File: rtl/shared_booth_mul_arbiter.sv
// shared_booth_mul_arbiter: round-robin arbiter sharing one radix-2 Booth bit-serial signed multiplier
module shared_booth_mul_arbiter #(
  parameter int N = 8,
  parameter int R = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [R-1:0]         req_valid,
  input  logic [R*N-1:0]       req_a,
  input  logic [R*N-1:0]       req_x,
  output logic [R-1:0]         req_ready,
  output logic                 rsp_valid,
  output logic [$clog2(R)-1:0] rsp_id,
  output logic [2*N-1:0]       rsp_p,
  input  logic                 rsp_ready,
  output logic                 busy
);
  localparam int IW = $clog2(R);
  localparam int CW = $clog2(N+1);
  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
  state_t state, state_nx;
  logic [N:0]    a_r, h_r, hn;
  logic [N-1:0]  l_r, sel_a, sel_x;
  logic          q_r, gnt_any;
  logic [CW-1:0] cnt;
  logic [IW-1:0] last_id, gnt_id;
  // round-robin search upward from last_id+1; lowest offset wins, so scan offsets high to low
  always_comb begin
    logic [IW-1:0] idx;
    idx = '0;
    gnt_any = 1'b0;
    gnt_id = '0;
    for (int k = R-1; k >= 0; k--) begin
      idx = IW'((int'(last_id) + 1 + k) % R);
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign sel_a = req_a[gnt_id*N +: N];
  assign sel_x = req_x[gnt_id*N +: N];
  assign req_ready = (state == IDLE && gnt_any) ? R'(1) << gnt_id : '0;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  assign hn = ({l_r[0], q_r} == 2'b01) ? h_r + a_r :
              ({l_r[0], q_r} == 2'b10) ? h_r - a_r : h_r;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next-state: accept in IDLE, N Booth steps in RUN, hold until consumer takes the product
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = gnt_any ? RUN : IDLE;
      RUN:     state_nx = (cnt == CW'(1)) ? RESP : RUN;
      RESP:    state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // operand latch on accept, then add/subtract and arithmetic shift of {H,L,q} each RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      h_r <= '0;
      l_r <= '0;
      q_r <= 1'b0;
      cnt <= '0;
      last_id <= IW'(R-1);
      rsp_id <= '0;
      rsp_p <= '0;
    end else if (state == IDLE && gnt_any) begin
      a_r <= {sel_a[N-1], sel_a};
      h_r <= '0;
      l_r <= sel_x;
      q_r <= 1'b0;
      cnt <= CW'(N);
      last_id <= gnt_id;
      rsp_id <= gnt_id;
    end else if (state == RUN) begin
      h_r <= {hn[N], hn[N:1]};
      l_r <= {hn[0], l_r[N-1:1]};
      q_r <= l_r[0];
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) rsp_p <= {hn, l_r[N-1:1]};
    end
  end
endmodule
